// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell plus a carry flop, LSB first, one bit per clk.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// state | meaning
// IDLE  | waiting for start; operands loaded when start is sampled high
// RUN   | one operand bit processed per edge, LSB first
// DONE  | result published last edge; done pulse, back to IDLE next edge
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             fa_s, fa_c;
    logic             last_bit;
    logic [WIDTH-1:0] res_shift;

    full_adder u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    assign last_bit  = (cnt_q == CW'(WIDTH - 1));
    // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    assign res_shift = (res_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = res_shift;
                carry_d = fa_c;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    sum_d   = res_shift;
                    cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB on this edge.
                    ovf_d   = carry_q ^ fa_c;
`endif
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed and exhaustive checks of serial_adder (WIDTH=8); lane 0 carries the directed
// sequence, all lanes share the exhaustive sweep. Honours SERIAL_ADDER_OVF_EN.

module tb_serial_adder;
    localparam int W  = 8;
    localparam int NL = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a_l     [NL];
    logic [W-1:0] b_l     [NL];
    logic         cin_l   [NL];
    logic         start_l [NL];
    logic [W-1:0] sum_l   [NL];
    logic         cout_l  [NL];
    logic         busy_l  [NL];
    logic         done_l  [NL];
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf_l   [NL];
`endif

    int n_checks = 0;
    int n_errors = 0;

    for (genvar g = 0; g < NL; g++) begin : g_lane
        serial_adder #(.WIDTH(W)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start_l[g]),
            .a     (a_l[g]),
            .b     (b_l[g]),
            .cin   (cin_l[g]),
            .sum   (sum_l[g]),
            .cout  (cout_l[g]),
            .busy  (busy_l[g]),
            .done  (done_l[g])
`ifdef SERIAL_ADDER_OVF_EN
            ,
            .ovf   (ovf_l[g])
`endif
        );
    end

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Start on lane 0, scramble inputs after the load edge, check timing and result.
    task automatic op_check(input string tag, input logic [7:0] av, input logic [7:0] bv,
                            input logic cv, input logic [8:0] exp9);
        a_l[0] = av; b_l[0] = bv; cin_l[0] = cv; start_l[0] = 1'b1;
        tick();
        start_l[0] = 1'b0;
        a_l[0] = ~av; b_l[0] = ~bv; cin_l[0] = ~cv;
        for (int e = 1; e <= W; e++) begin
            tick();
            check({tag, "_done"}, {31'd0, done_l[0]}, {31'd0, (e == W)});
            check({tag, "_busy"}, {31'd0, busy_l[0]}, 32'd1);
        end
        check({tag, "_res"}, {23'd0, cout_l[0], sum_l[0]}, {23'd0, exp9});
        tick();
        check({tag, "_done_end"}, {31'd0, done_l[0]}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy_l[0]}, 32'd0);
        check({tag, "_hold"}, {23'd0, cout_l[0], sum_l[0]}, {23'd0, exp9});
    endtask

    logic [7:0] bb_a [4];
    logic [7:0] bb_b [4];
    logic       bb_c [4];
    logic [8:0] bb_e [4];

    initial begin
        int k;
        int t;
        logic [8:0] full;
        logic       eovf;

        rst_n = 1'b0;
        for (int l = 0; l < NL; l++) begin
            a_l[l] = '0; b_l[l] = '0; cin_l[l] = 1'b0; start_l[l] = 1'b0;
        end
        tick(); tick(); tick();
        check("rst_sum",  {24'd0, sum_l[0]}, 32'd0);
        check("rst_cout", {31'd0, cout_l[0]}, 32'd0);
        check("rst_busy", {31'd0, busy_l[0]}, 32'd0);
        check("rst_done", {31'd0, done_l[0]}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf",  {31'd0, ovf_l[0]}, 32'd0);
`endif
        #3 rst_n = 1'b1;
        tick();

        op_check("zero", 8'h00, 8'h00, 1'b0, 9'h000);
        op_check("ff01", 8'hFF, 8'h01, 1'b0, 9'h100);
`ifdef SERIAL_ADDER_OVF_EN
        check("ff01_ovf", {31'd0, ovf_l[0]}, 32'd0);
`endif
        op_check("ffff1", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
`ifdef SERIAL_ADDER_OVF_EN
        check("ffff1_ovf", {31'd0, ovf_l[0]}, 32'd0);
`endif
        op_check("7f01", 8'h7F, 8'h01, 1'b0, 9'h080);
`ifdef SERIAL_ADDER_OVF_EN
        check("7f01_ovf", {31'd0, ovf_l[0]}, 32'd1);
`endif

        // Abort an operation 4 cycles into RUN.
        a_l[0] = 8'h55; b_l[0] = 8'h22; cin_l[0] = 1'b0; start_l[0] = 1'b1;
        tick();
        start_l[0] = 1'b0;
        for (int e = 0; e < 4; e++) tick();
        check("abort_busy_pre", {31'd0, busy_l[0]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy_l[0]}, 32'd0);
        check("abort_sum",  {24'd0, sum_l[0]}, 32'd0);
        check("abort_cout", {31'd0, cout_l[0]}, 32'd0);
        check("abort_done", {31'd0, done_l[0]}, 32'd0);
        tick();
        for (int e = 0; e < 3; e++) begin
            tick();
            check("abort_rst_done", {31'd0, done_l[0]}, 32'd0);
        end
        #3 rst_n = 1'b1;
        for (int e = 0; e < 12; e++) begin
            tick();
            check("abort_post_done", {31'd0, done_l[0]}, 32'd0);
            check("abort_post_busy", {31'd0, busy_l[0]}, 32'd0);
        end
        op_check("after_rst", 8'h12, 8'h34, 1'b0, 9'h046);

        // Back-to-back with start held high: a load every 10 edges.
        bb_a[0] = 8'h11; bb_b[0] = 8'h22; bb_c[0] = 1'b0; bb_e[0] = 9'h033;
        bb_a[1] = 8'hF0; bb_b[1] = 8'h0F; bb_c[1] = 1'b1; bb_e[1] = 9'h100;
        bb_a[2] = 8'hA5; bb_b[2] = 8'h5A; bb_c[2] = 1'b0; bb_e[2] = 9'h0FF;
        bb_a[3] = 8'h80; bb_b[3] = 8'h80; bb_c[3] = 1'b1; bb_e[3] = 9'h101;
        a_l[0] = bb_a[0]; b_l[0] = bb_b[0]; cin_l[0] = bb_c[0]; start_l[0] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            check("b2b_load", {31'd0, busy_l[0]}, 32'd1);
            a_l[0] = ~bb_a[j]; b_l[0] = ~bb_b[j] + 8'd3; cin_l[0] = ~bb_c[j];
            for (int e = 1; e <= 9; e++) begin
                tick();
                check("b2b_done", {31'd0, done_l[0]}, {31'd0, (e == 8)});
                check("b2b_busy", {31'd0, busy_l[0]}, {31'd0, (e != 9)});
                if (e == 8)
                    check("b2b_res", {23'd0, cout_l[0], sum_l[0]}, {23'd0, bb_e[j]});
                if (e == 9) begin
                    if (j < 3) begin
                        a_l[0] = bb_a[j+1]; b_l[0] = bb_b[j+1]; cin_l[0] = bb_c[j+1];
                    end else begin
                        start_l[0] = 1'b0;
                    end
                end
            end
        end
        tick();
        check("b2b_stop", {31'd0, busy_l[0]}, 32'd0);

        // Exhaustive sweep, NL combinations per operation.
        for (int g = 0; g < (1 << 17) / NL; g++) begin
            for (int l = 0; l < NL; l++) begin
                k = g * NL + l;
                a_l[l] = k[7:0]; b_l[l] = k[15:8]; cin_l[l] = k[16]; start_l[l] = 1'b1;
            end
            tick();
            for (int l = 0; l < NL; l++) start_l[l] = 1'b0;
            t = 0;
            while (!done_l[0] && t < 20) begin
                tick();
                t++;
            end
            check("exh_done", {31'd0, done_l[0]}, 32'd1);
            for (int l = 0; l < NL; l++) begin
                k = g * NL + l;
                full = {1'b0, k[7:0]} + {1'b0, k[15:8]} + {8'd0, k[16]};
                eovf = (k[7] == k[15]) && (full[7] != k[7]);
                check("exh_res", {23'd0, cout_l[l], sum_l[l]}, {23'd0, full});
`ifdef SERIAL_ADDER_OVF_EN
                check("exh_ovf", {31'd0, ovf_l[l]}, {31'd0, eovf});
`endif
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
